// File: rtl/ex_mem_skid.sv
// EX->MEM pipeline register with a main + skid entry so MEM back-pressure never reaches ex_ready combinationally.
// Optional stall counter port stall_cycles is built only when EX_MEM_PERF_EN is defined.
module ex_mem_skid #(
   parameter int         XLEN     = 32,
   parameter int         REG_AW   = 5,
   parameter logic [4:0] NO_LOAD  = 5'd0,
   parameter logic [2:0] NO_STORE = 3'd0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ex_valid,
   output logic              ex_ready,
   input  logic [XLEN-1:0]   ex_rd,
   input  logic              ex_rd_en,
   input  logic [REG_AW-1:0] ex_rd_addr,
   input  logic [4:0]        ex_load_flag,
   input  logic [2:0]        ex_store_flag,
   input  logic [XLEN-1:0]   ex_store_data,
   input  logic              flush,
   output logic              mem_valid,
   input  logic              mem_ready,
   output logic [XLEN-1:0]   mem_rd,
   output logic              mem_rd_en,
   output logic [REG_AW-1:0] mem_rd_addr,
   output logic [4:0]        mem_load_flag,
   output logic [2:0]        mem_store_flag,
   output logic [XLEN-1:0]   mem_store_data,
   output logic              fwd_valid,
   output logic              fwd_is_load
`ifdef EX_MEM_PERF_EN
   ,
   output logic [31:0]       stall_cycles
`endif
);

   localparam int PW = 2*XLEN + REG_AW + 9;

   typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

   state_t          state_reg, state_next;
   logic [PW-1:0]   main_reg, skid_reg;
   logic [PW-1:0]   in_payload, bubble_payload, out_payload;
   logic            push, pop;
   logic            main_from_in, main_from_skid, skid_from_in;

   assign in_payload     = {ex_rd, ex_rd_en, ex_rd_addr, ex_load_flag, ex_store_flag, ex_store_data};
   assign bubble_payload = {{XLEN{1'b0}}, 1'b0, {REG_AW{1'b0}}, NO_LOAD, NO_STORE, {XLEN{1'b0}}};

   // ex_ready decodes the state register only, breaking the mem_ready -> ex_ready path
   assign ex_ready  = (state_reg != TWO);
   assign mem_valid = (state_reg != EMPTY);
   assign push      = ex_valid & ex_ready;
   assign pop       = mem_valid & mem_ready;

   always_comb begin
      state_next     = state_reg;
      main_from_in   = 1'b0;
      main_from_skid = 1'b0;
      skid_from_in   = 1'b0;
      case (state_reg)
         EMPTY: begin
            if (push) begin
               main_from_in = 1'b1;
               state_next   = ONE;
            end
         end
         ONE: begin
            if (push && pop) begin
               main_from_in = 1'b1;
            end else if (push) begin
               skid_from_in = 1'b1;
               state_next   = TWO;
            end else if (pop) begin
               state_next   = EMPTY;
            end
         end
         TWO: begin
            if (pop) begin
               main_from_skid = 1'b1;
               state_next     = ONE;
            end
         end
         default: state_next = EMPTY;
      endcase
      // flush wins over any push or pop in the same cycle
      if (flush) begin
         state_next     = EMPTY;
         main_from_in   = 1'b0;
         main_from_skid = 1'b0;
         skid_from_in   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= EMPTY;
      end else begin
         state_reg <= state_next;
      end
   end

   // Payload storage needs no reset: it is only observed while the matching state says it is valid
   always_ff @(posedge clk) begin
      if (main_from_in) begin
         main_reg <= in_payload;
      end else if (main_from_skid) begin
         main_reg <= skid_reg;
      end
      if (skid_from_in) begin
         skid_reg <= in_payload;
      end
   end

   assign out_payload = mem_valid ? main_reg : bubble_payload;
   assign {mem_rd, mem_rd_en, mem_rd_addr, mem_load_flag, mem_store_flag, mem_store_data} = out_payload;

   assign fwd_valid   = mem_valid & mem_rd_en & (mem_rd_addr != '0);
   assign fwd_is_load = mem_valid & (mem_load_flag != NO_LOAD);

`ifdef EX_MEM_PERF_EN
   logic [31:0] stall_cycles_reg;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stall_cycles_reg <= 32'd0;
      end else if (mem_valid && !mem_ready) begin
         stall_cycles_reg <= stall_cycles_reg + 32'd1;
      end
   end

   assign stall_cycles = stall_cycles_reg;
`endif

endmodule
